// File: rtl/pad_input_cond_pkg.sv
// Shared types and defaults for the pad input conditioner.
package pad_input_cond_pkg;

  // Debounce filter states: STABLE tracks a settled level, CHECK is counting
  // how long a new level has persisted.
  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } pad_cond_state_e;

  localparam int PAD_COND_SYNC_STAGES_DEF = 2;
  localparam int PAD_COND_CNT_W_DEF       = 16;

endpackage

// File: rtl/pad_input_sync.sv
// Multi-flop synchroniser with a defined reset value. Kept as its own module
// so a technology synchroniser cell can replace it without touching the filter.
module pad_input_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through STAGES flops; all flops are reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= {STAGES{RESET_VALUE}};
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/pad_input_conditioner.sv
// Synchronises a raw pad level, rejects glitches shorter than a programmable
// persistence, and produces a clean level, edge strobes and a sticky event flag.
//
// Handshake: there is none; every output is a registered level or a
// single-cycle strobe, valid in every cycle after reset.
module pad_input_conditioner
  import pad_input_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = PAD_COND_SYNC_STAGES_DEF,
  parameter int   CNT_W       = PAD_COND_CNT_W_DEF,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] debounce_cycles_i,
  input  logic             rise_en_i,
  input  logic             fall_en_i,
  input  logic             clear_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             event_pending_o,
  output pad_cond_state_e  dbg_state_o
);

  logic            sync_q;
  pad_cond_state_e state;
  logic [CNT_W-1:0] cnt;

  pad_input_sync #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pad_i),
    .q_o   (sync_q)
  );

  // Debounce FSM: a new synchronised level must persist until cnt reaches N
  // before it is committed to level_o; strobes mark the commit cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= STABLE;
      cnt     <= '0;
      level_o <= RESET_VALUE;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (!en_i) begin
        // Disabled: drop any partial count and hold the current level.
        state <= STABLE;
        cnt   <= '0;
      end else begin
        case (state)
          STABLE: begin
            if (sync_q != level_o) begin
              if (debounce_cycles_i != '0) begin
                state <= CHECK;
                cnt   <= CNT_W'(1);
              end else begin
                // N = 0 bypasses the filter: commit immediately.
                level_o <= sync_q;
                rise_o  <= sync_q;
                fall_o  <= ~sync_q;
              end
            end
          end
          CHECK: begin
            if (sync_q == level_o) begin
              // Input went back before persisting long enough: glitch.
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt >= debounce_cycles_i) begin
              // N is re-sampled every cycle, so lowering it commits at once.
              level_o <= sync_q;
              rise_o  <= sync_q;
              fall_o  <= ~sync_q;
              state   <= STABLE;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Sticky event flag built from the registered strobes; a set beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_pending_o <= 1'b0;
    end else if ((rise_o & rise_en_i) | (fall_o & fall_en_i)) begin
      event_pending_o <= 1'b1;
    end else if (clear_i) begin
      event_pending_o <= 1'b0;
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner with a persistence-count model and
// hand-computed checkpoints.
module tb_pad_input_conditioner;
  import pad_input_cond_pkg::*;

  localparam int   S  = 2;
  localparam int   W  = 16;
  localparam logic RV = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           pad = 1'b0;
  logic           en = 1'b1;
  logic [W-1:0]   n_cyc = 16'd3;
  logic           rise_en = 1'b0;
  logic           fall_en = 1'b0;
  logic           clear = 1'b0;
  logic           level, rise, fall, evt;
  pad_cond_state_e dbg_state;

  pad_input_conditioner #(
    .SYNC_STAGES (S),
    .CNT_W       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .pad_i             (pad),
    .en_i              (en),
    .debounce_cycles_i (n_cyc),
    .rise_en_i         (rise_en),
    .fall_en_i         (fall_en),
    .clear_i           (clear),
    .level_o           (level),
    .rise_o            (rise),
    .fall_o            (fall),
    .event_pending_o   (evt),
    .dbg_state_o       (dbg_state)
  );

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // sync_q is simply the pad sampled S edges earlier; the filter commits a new
  // level once it has differed from the current level on more than N
  // consecutive enabled edges (i.e. the run of earlier differing edges >= N).
  logic        m_hist[$];
  logic        m_level = RV, m_rise = 1'b0, m_fall = 1'b0, m_event = 1'b0;
  int unsigned m_run = 0;

  always @(posedge clk) begin
    logic sq;
    logic nr, nf;
    if (rst) begin
      m_hist = {};
      for (int i = 0; i < S; i++) m_hist.push_front(RV);
      m_level = RV; m_rise = 1'b0; m_fall = 1'b0; m_event = 1'b0; m_run = 0;
    end else begin
      sq = m_hist[S-1];
      m_hist.push_front(pad);
      void'(m_hist.pop_back());
      if ((m_rise && rise_en) || (m_fall && fall_en)) m_event = 1'b1;
      else if (clear) m_event = 1'b0;
      nr = 1'b0; nf = 1'b0;
      if (en && (sq != m_level)) begin
        if (m_run >= int'(n_cyc)) begin
          m_level = sq; nr = sq; nf = ~sq; m_run = 0;
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      m_rise = nr; m_fall = nf;
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_level", 32'(level), 32'(m_level));
      check("model_rise",  32'(rise),  32'(m_rise));
      check("model_fall",  32'(fall),  32'(m_fall));
      check("model_event", 32'(evt),   32'(m_event));
      check("no_dual_strobe", 32'(rise & fall), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (rise) found = 1'b1;
    end
    check("wait_rise_timeout", 32'(found), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit found;
    int r_at, f_at, strobes;

    // Reset and idle low.
    cycles(2);
    rst = 1'b0;
    chk_on = 1'b1;
    cycles(4);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rise",  32'(rise),  32'd0);
    check("rst_fall",  32'(fall),  32'd0);
    check("rst_event", 32'(evt),   32'd0);
    check("rst_state", 32'(dbg_state), 32'(STABLE));

    // Clean rise with N = 3: level changes after edge 5.
    pad = 1'b1;
    cycles(5);
    check("lat_edge4_level", 32'(level), 32'd0);
    cycles(1);
    check("lat_edge5_level", 32'(level), 32'd1);
    check("lat_edge5_rise",  32'(rise),  32'd1);
    cycles(1);
    check("lat_rise_single", 32'(rise), 32'd0);
    check("lat_no_event",    32'(evt),  32'd0);
    pad = 1'b0;
    cycles(10);

    // 3-cycle pulse is rejected.
    pad = 1'b1;
    cycles(3);
    pad = 1'b0;
    strobes = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rise || fall || level) strobes++;
    end
    check("glitch3_rejected", 32'(strobes), 32'd0);

    // 4-cycle pulse passes: rise after edge 5, fall after edge 9.
    r_at = -1; f_at = -1;
    pad = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 4) pad = 1'b0;
      if (rise) r_at = c;
      if (fall) f_at = c;
    end
    check("pulse4_rise_at", 32'(r_at), 32'd6);
    check("pulse4_fall_at", 32'(f_at), 32'd10);

    // N = 0 bypass with pad toggling every cycle.
    n_cyc = 16'd0;
    cycles(4);
    for (int i = 0; i < 12; i++) begin
      pad = (i % 2 == 0);
      @(negedge clk);
      if (i >= 2) begin
        check("bypass_level", 32'(level), 32'((i % 2) == 0));
        check("bypass_rise",  32'(rise),  32'((i % 2) == 0));
        check("bypass_fall",  32'(fall),  32'((i % 2) != 0));
      end
    end
    pad = 1'b0;
    cycles(4);

    // Sticky event flag: set one cycle after rise, set beats clear, clear alone.
    n_cyc = 16'd3;
    rise_en = 1'b1;
    pad = 1'b1;
    wait_rise(20, found);
    check("evt_at_strobe", 32'(evt), 32'd0);
    cycles(1);
    check("evt_after_strobe", 32'(evt), 32'd1);
    pad = 1'b0;
    cycles(12);
    pad = 1'b1;
    wait_rise(20, found);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("evt_set_wins", 32'(evt), 32'd1);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("evt_cleared", 32'(evt), 32'd0);
    rise_en = 1'b0;
    pad = 1'b0;
    cycles(12);

    // N lowered mid-count: N = 10, cnt reaches 4, then N = 2 commits next edge.
    n_cyc = 16'd10;
    pad = 1'b1;
    cycles(6);
    check("ndrop_before", 32'(level), 32'd0);
    n_cyc = 16'd2;
    cycles(1);
    check("ndrop_level", 32'(level), 32'd1);
    check("ndrop_rise",  32'(rise),  32'd1);
    pad = 1'b0;
    cycles(8);

    // Reset mid-CHECK discards the partial count.
    n_cyc = 16'd10;
    pad = 1'b1;
    cycles(6);
    check("midchk_state", 32'(dbg_state), 32'(CHECK));
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("midrst_level", 32'(level), 32'(RV));
    check("midrst_rise",  32'(rise),  32'd0);
    check("midrst_state", 32'(dbg_state), 32'(STABLE));

    // Disable mid-CHECK: count is cleared and level held.
    cycles(6);
    en = 1'b0;
    cycles(3);
    check("dis_level", 32'(level), 32'd0);
    check("dis_state", 32'(dbg_state), 32'(STABLE));
    en = 1'b1;
    cycles(10);
    check("reen_not_yet", 32'(level), 32'd0);
    cycles(1);
    check("reen_level", 32'(level), 32'd1);
    check("reen_rise",  32'(rise),  32'd1);
    cycles(4);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
